// File: rtl/scope_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : scope_pkg
//  Purpose  : Shared encodings and defaults for the scope trigger/capture path
//  Revision : 1.0  initial release
// ============================================================================
package scope_pkg;

    // Default widths
    localparam int DEF_DATA_W = 12;
    localparam int DEF_ADDR_W = 10;

    // Sequencer states
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PREFILL = 3'd1;
    localparam logic [2:0] ST_ARMED   = 3'd2;
    localparam logic [2:0] ST_POST    = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;

    // Trigger modes (2'b11 is folded onto normal when latched)
    localparam logic [1:0] TM_AUTO   = 2'b00;
    localparam logic [1:0] TM_NORMAL = 2'b01;
    localparam logic [1:0] TM_SINGLE = 2'b10;

    // Trigger slope
    localparam logic SLOPE_RISE = 1'b0;
    localparam logic SLOPE_FALL = 1'b1;

    // Counter width for a count limit, never narrower than one bit
    function automatic int cnt_w(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trig_detect.sv
`default_nettype none
// ============================================================================
//  Module   : trig_detect
//  Purpose  : Level/slope crossing detector; remembers the previous written
//             sample and flags a crossing on the current strobe
//  Revision : 1.0  initial release
// ============================================================================
module trig_detect
    import scope_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    output logic              hit
);

    logic [DATA_W-1:0] r_prev;
    logic              r_prev_valid;
    logic              w_rise;
    logic              w_fall;

    // Previous-sample history; cleared at the start of every capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (clear) begin
            r_prev_valid <= 1'b0;
        end else if (sample_en) begin
            r_prev       <= sample_in;
            r_prev_valid <= 1'b1;
        end
    end

    // Unsigned crossing compares; a hit needs a valid previous sample
    assign w_rise = (r_prev < trig_level) && (sample_in >= trig_level);
    assign w_fall = (r_prev > trig_level) && (sample_in <= trig_level);
    assign hit    = sample_en && r_prev_valid &&
                    ((trig_slope == SLOPE_FALL) ? w_fall : w_rise);

endmodule
`default_nettype wire

// File: rtl/trigger_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : trigger_capture_ctrl
//  Purpose  : Circular sample writer with pre-trigger window, level/slope
//             trigger, auto-trigger timeout and frame freeze/holdoff
//  Revision : 1.0  initial release
// ============================================================================
module trigger_capture_ctrl
    import scope_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = 640,
    parameter int PRETRIG = 64,
    parameter int HOLDOFF = 262144,
    parameter int AUTO_TO = 4096
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic [1:0]        trig_mode,
    input  logic              arm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] base_addr,
    output logic              frame_valid,
    output logic              frame_done,
    output logic              triggered,
    output logic [2:0]        state
);

    localparam int PRE_W  = cnt_w(PRETRIG);
    localparam int AUTO_W = cnt_w(AUTO_TO);
    localparam int POST_W = cnt_w(DEPTH);
    localparam int HOLD_W = cnt_w(HOLDOFF);

    localparam logic [PRE_W-1:0]  C_PRE_LAST  = PRE_W'(PRETRIG - 1);
    localparam logic [AUTO_W-1:0] C_AUTO_LAST = AUTO_W'(AUTO_TO - 1);
    localparam logic [POST_W-1:0] C_POST_INIT = POST_W'(DEPTH - PRETRIG - 1);
    localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(HOLDOFF - 1);
    localparam logic [ADDR_W-1:0] C_PTR_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   C_PRETRIG_X = (ADDR_W + 1)'(PRETRIG);
    localparam logic [ADDR_W:0]   C_DEPTH_X   = (ADDR_W + 1)'(DEPTH);

    logic [2:0]        r_state;
    logic [1:0]        r_mode;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [ADDR_W-1:0] r_base_addr;
    logic              r_frame_valid;
    logic              r_frame_done;
    logic              r_triggered;
    logic [PRE_W-1:0]  r_pre_cnt;
    logic [AUTO_W-1:0] r_auto_cnt;
    logic [POST_W-1:0] r_post_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;

    logic              w_write;
    logic              w_hit;
    logic              w_force;
    logic              w_idle_go;
    logic              w_hold_done;
    logic              w_enter_prefill;
    logic [1:0]        w_mode_in;
    logic [ADDR_W:0]   w_base_diff;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_ptr_next;

    // Acquisition strobes are only honoured while a capture is in flight
    assign w_write = sample_en &&
                     ((r_state == ST_PREFILL) || (r_state == ST_ARMED) ||
                      (r_state == ST_POST));

    assign w_mode_in       = (trig_mode == 2'b11) ? TM_NORMAL : trig_mode;
    assign w_idle_go       = (r_state == ST_IDLE) && ((trig_mode != TM_SINGLE) || arm);
    assign w_hold_done     = (r_state == ST_HOLD) && (r_hold_cnt == C_HOLD_LAST);
    assign w_enter_prefill = w_idle_go || (w_hold_done && (r_mode != TM_SINGLE));
    assign w_force         = (r_mode == TM_AUTO) && (r_auto_cnt == C_AUTO_LAST);

    // Frame start = trigger pointer minus pre-trigger window, modulo DEPTH
    assign w_base_diff = {1'b0, r_ptr} - C_PRETRIG_X;
    assign w_base      = w_base_diff[ADDR_W] ? ADDR_W'(w_base_diff + C_DEPTH_X)
                                             : w_base_diff[ADDR_W-1:0];
    assign w_ptr_next  = (r_ptr == C_PTR_LAST) ? '0 : r_ptr + 1'b1;

    trig_detect #(
        .DATA_W (DATA_W)
    ) u_trig_detect (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (w_enter_prefill),
        .sample_en  (w_write),
        .sample_in  (sample_in),
        .trig_level (trig_level),
        .trig_slope (trig_slope),
        .hit        (w_hit)
    );

    // Sequencer, buffer write port and frame bookkeeping
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_mode        <= TM_AUTO;
            r_ptr         <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_base_addr   <= '0;
            r_frame_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            r_triggered   <= 1'b0;
            r_pre_cnt     <= '0;
            r_auto_cnt    <= '0;
            r_post_cnt    <= '0;
            r_hold_cnt    <= '0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;

            if (w_write) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_ptr;
                r_wr_data <= sample_in;
                r_ptr     <= w_ptr_next;
            end

            if (w_enter_prefill) begin
                r_state       <= ST_PREFILL;
                r_mode        <= w_mode_in;
                r_frame_valid <= 1'b0;
                r_pre_cnt     <= '0;
            end

            case (r_state)
                ST_IDLE: ;
                ST_PREFILL: begin
                    if (sample_en) begin
                        if (r_pre_cnt == C_PRE_LAST) begin
                            r_state    <= ST_ARMED;
                            r_auto_cnt <= '0;
                        end else begin
                            r_pre_cnt <= r_pre_cnt + 1'b1;
                        end
                    end
                end
                ST_ARMED: begin
                    if (sample_en) begin
                        if (w_hit || w_force) begin
                            r_base_addr <= w_base;
                            r_post_cnt  <= C_POST_INIT;
                            r_triggered <= w_hit;
                            if (C_POST_INIT == '0) begin
                                r_state       <= ST_HOLD;
                                r_hold_cnt    <= '0;
                                r_frame_done  <= 1'b1;
                                r_frame_valid <= 1'b1;
                            end else begin
                                r_state <= ST_POST;
                            end
                        end else begin
                            r_auto_cnt <= r_auto_cnt + 1'b1;
                        end
                    end
                end
                ST_POST: begin
                    if (sample_en) begin
                        r_post_cnt <= r_post_cnt - 1'b1;
                        if (r_post_cnt == POST_W'(1)) begin
                            r_state       <= ST_HOLD;
                            r_hold_cnt    <= '0;
                            r_frame_done  <= 1'b1;
                            r_frame_valid <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_hold_done) begin
                        if (r_mode == TM_SINGLE) begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign base_addr   = r_base_addr;
    assign frame_valid = r_frame_valid;
    assign frame_done  = r_frame_done;
    assign triggered   = r_triggered;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_trigger_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trigger_capture_ctrl
//  Purpose  : Directed self-checking bench for trigger_capture_ctrl
//  Revision : 1.0  initial release
// ============================================================================
module tb_trigger_capture_ctrl;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 4;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              sample_en = 1'b0;
    logic [DATA_W-1:0] sample_in = '0;
    logic [DATA_W-1:0] trig_level = 12'd100;
    logic              trig_slope = 1'b0;
    logic [1:0]        trig_mode = 2'b01;
    logic              arm = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] base_addr;
    logic              frame_valid;
    logic              frame_done;
    logic              triggered;
    logic [2:0]        state;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic seen_done = 1'b0;
    logic in_frame  = 1'b0;
    int   fw        = 0;

    trigger_capture_ctrl #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (16),
        .PRETRIG (4),
        .HOLDOFF (8),
        .AUTO_TO (32)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .sample_en   (sample_en),
        .sample_in   (sample_in),
        .trig_level  (trig_level),
        .trig_slope  (trig_slope),
        .trig_mode   (trig_mode),
        .arm         (arm),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .base_addr   (base_addr),
        .frame_valid (frame_valid),
        .frame_done  (frame_done),
        .triggered   (triggered),
        .state       (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One-cycle sample strobe; outputs of that edge are visible on return
    task automatic strobe(input logic [DATA_W-1:0] v);
        sample_en = 1'b1;
        sample_in = v;
        tick();
        sample_en = 1'b0;
        if (frame_done) seen_done = 1'b1;
    endtask

    task automatic gap();
        repeat (3) tick();
    endtask

    task automatic wait_state(input string tag, input logic [2:0] target, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (state == target) break;
            tick();
        end
        check(tag, 32'(state), 32'(target));
    endtask

    task automatic do_reset(input logic [1:0] mode);
        reset_n   = 1'b0;
        trig_mode = mode;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset values
        repeat (3) tick();
        check("rst_state", 32'(state), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_base", 32'(base_addr), 0);
        check("rst_valid", 32'(frame_valid), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_trig", 32'(triggered), 0);

        // ---------------- normal rising ramp, trigger at k=5
        reset_n = 1'b1;
        tick();
        check("s2_prefill", 32'(state), 1);
        for (int k = 0; k <= 16; k++) begin
            strobe(12'(20 * k));
            check("s2_wr_en", 32'(wr_en), 1);
            check("s2_wr_addr", 32'(wr_addr), 32'(k % 16));
            check("s2_wr_data", 32'(wr_data), 32'(20 * k));
            check("s2_state", 32'(state), (k < 3) ? 1 : (k < 5) ? 2 : (k < 16) ? 3 : 4);
            check("s2_done", 32'(frame_done), 32'(k == 16));
            if (k == 5) begin
                check("s2_base", 32'(base_addr), 1);
                check("s2_trig", 32'(triggered), 1);
            end
            gap();
        end
        check("s2_valid", 32'(frame_valid), 1);
        check("s2_done_gone", 32'(frame_done), 0);
        strobe(12'd999);
        check("s2_hold_no_wr", 32'(wr_en), 0);
        check("s2_hold_state", 32'(state), 4);
        gap();
        wait_state("s2_rearm", 3'd1, 20);
        check("s2_valid_clr", 32'(frame_valid), 0);

        // ---------------- falling slope on rising ramp: never triggers
        trig_slope = 1'b1;
        seen_done  = 1'b0;
        for (int k = 0; k < 110; k++) begin
            strobe(12'(20 * k));
            gap();
        end
        check("s3_state", 32'(state), 2);
        check("s3_no_done", 32'(seen_done), 0);

        // ---------------- auto mode, constant 50 below level
        trig_slope = 1'b0;
        do_reset(2'b00);
        check("s4_prefill", 32'(state), 1);
        for (int i = 0; i < 4; i++) begin
            strobe(12'd50);
            gap();
        end
        check("s4_armed", 32'(state), 2);
        seen_done = 1'b0;
        for (int i = 0; i < 31; i++) begin
            strobe(12'd50);
            gap();
        end
        check("s4_still_armed", 32'(state), 2);
        strobe(12'd50);
        check("s4_forced", 32'(state), 3);
        check("s4_trig0", 32'(triggered), 0);
        check("s4_base", 32'(base_addr), 15);
        check("s4_addr", 32'(wr_addr), 3);
        gap();
        for (int i = 0; i < 11; i++) begin
            strobe(12'd50);
            check("s4_done", 32'(frame_done), 32'(i == 10));
            gap();
        end
        check("s4_hold", 32'(state), 4);
        check("s4_no_early_done", 32'(seen_done), 1);

        // ---------------- single shot
        do_reset(2'b10);
        check("s5_idle", 32'(state), 0);
        for (int i = 0; i < 3; i++) begin
            strobe(12'd500);
            check("s5_no_wr", 32'(wr_en), 0);
            gap();
        end
        check("s5_wait_arm", 32'(state), 0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("s5_armed_go", 32'(state), 1);
        for (int k = 0; k <= 16; k++) begin
            strobe(12'(20 * k));
            check("s5_done", 32'(frame_done), 32'(k == 16));
            gap();
            if (k == 8) begin
                arm = 1'b1;
                tick();
                arm = 1'b0;
                check("s5_arm_in_post", 32'(state), 3);
            end
        end
        check("s5_base", 32'(base_addr), 1);
        wait_state("s5_back_idle", 3'd0, 30);
        check("s5_valid_kept", 32'(frame_valid), 1);
        check("s5_trig", 32'(triggered), 1);
        repeat (10) tick();
        check("s5_stay_idle", 32'(state), 0);

        // ---------------- wrap boundary: trigger at ptr=2
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("s6_prefill", 32'(state), 1);
        for (int i = 0; i < 4; i++) begin
            strobe(12'd0);
            check("s6_pre_addr", 32'(wr_addr), 32'((1 + i) % 16));
            gap();
        end
        for (int i = 0; i < 13; i++) begin
            strobe(12'd0);
            check("s6_arm_addr", 32'(wr_addr), 32'((5 + i) % 16));
            if (wr_addr == 4'd14) in_frame = 1'b1;
            if (in_frame && wr_en) fw++;
            gap();
        end
        check("s6_armed", 32'(state), 2);
        strobe(12'd200);
        check("s6_trig_addr", 32'(wr_addr), 2);
        check("s6_post", 32'(state), 3);
        check("s6_base", 32'(base_addr), 14);
        check("s6_trig", 32'(triggered), 1);
        if (in_frame && wr_en) fw++;
        gap();
        for (int i = 0; i < 11; i++) begin
            strobe(12'd300);
            check("s6_post_addr", 32'(wr_addr), 32'(3 + i));
            check("s6_done", 32'(frame_done), 32'(i == 10));
            if (in_frame && wr_en) fw++;
            gap();
        end
        check("s6_frame_writes", 32'(fw), 16);

        // ---------------- reset asserted during POST
        trig_slope = 1'b0;
        do_reset(2'b01);
        check("s1b_prefill", 32'(state), 1);
        for (int k = 0; k < 8; k++) begin
            strobe(12'(20 * k));
            if (k < 7) gap();
        end
        check("s1b_in_post", 32'(state), 3);
        check("s1b_wr_before", 32'(wr_en), 1);
        reset_n = 1'b0;
        #1;
        check("s1b_state", 32'(state), 0);
        check("s1b_wr_en", 32'(wr_en), 0);
        check("s1b_valid", 32'(frame_valid), 0);
        check("s1b_trig", 32'(triggered), 0);
        tick();
        reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trigger_capture_ctrl.md
Name: trigger_capture_ctrl

Overview:
Trigger and acquisition sequencer for one scope channel. Sits between the ADC channel output and the dual-port sample buffer. Writes samples circularly into the buffer and detects a level/slope trigger with a pre-trigger window. Freezes a complete frame for the VGA reader and reports the buffer address of the frame's first column (base_addr).

Parameters:
DATA_W, 12, sample width (ADC/buffer data width)
ADDR_W, 10, buffer address width
DEPTH, 640, samples per frame (one per screen column); must be <= 2**ADDR_W
PRETRIG, 64, samples kept before the trigger point; 1 <= PRETRIG < DEPTH
HOLDOFF, 262144, clock cycles the frame is frozen before re-arming
AUTO_TO, 4096, sample strobes in ARMED before auto mode forces a trigger

Ports:
clock  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous, active-low reset
sample_en  in  1  one-cycle strobe marking a new sample_in (write rate)
sample_in  in  DATA_W  ADC sample, valid when sample_en=1
trig_level  in  DATA_W  trigger threshold, unsigned
trig_slope  in  1  0 = rising, 1 = falling
trig_mode  in  2  00 auto, 01 normal, 10 single, 11 treated as normal
arm  in  1  single-shot arm pulse
wr_en  out  1  buffer write enable
wr_addr  out  ADDR_W  buffer write address
wr_data  out  DATA_W  buffer write data
base_addr  out  ADDR_W  buffer address of frame column 0; reader uses (base_addr+screenX) mod DEPTH
frame_valid  out  1  a completed frame is frozen in the buffer
frame_done  out  1  one-cycle pulse when a frame completes (drives resample LED)
triggered  out  1  1 = last frame from a real trigger, 0 = auto-forced
state  out  3  current FSM state, for debug/LED

Behaviour:
- Reset (async, reset_n=0): state=IDLE. wr_en, wr_addr, wr_data, base_addr, frame_valid, frame_done, triggered and all counters go to 0. Internal write pointer ptr=0 and prev_valid=0. Reset asserted mid-capture aborts immediately; no partial frame is flagged.
- States: IDLE=0, PREFILL=1, ARMED=2, POST=3, HOLD=4.
- Mode latch: trig_mode is latched only on entry to PREFILL. Changes during a capture take effect on the next capture.
- IDLE -> PREFILL on the next edge if mode != single, or if arm=1. On entry: frame_valid<=0, pre_cnt<=0, prev_valid<=0.
- Write rule (PREFILL/ARMED/POST, sample_en=1), all registered, 1-cycle latency:
  - wr_en<=1, wr_addr<=ptr, wr_data<=sample_in.
  - ptr<=(ptr==DEPTH-1)?0:ptr+1.
  - prev<=sample_in, prev_valid<=1.
  - Otherwise wr_en<=0.
- PREFILL: count writes; after the PRETRIG-th write, go to ARMED with auto_cnt=0.
- Trigger condition (ARMED, sample_en=1, prev_valid=1):
  - Rising: prev < trig_level && sample_in >= trig_level.
  - Falling: prev > trig_level && sample_in <= trig_level.
- On trigger:
  - The triggering sample is written at ptr.
  - base_addr <= (ptr - PRETRIG) mod DEPTH.
  - post_cnt <= DEPTH-PRETRIG-1.
  - triggered <= 1.
  - Go to POST. If post_cnt=0, go straight to HOLD.
- Auto mode: auto_cnt increments per ARMED strobe. When auto_cnt reaches AUTO_TO-1 on a strobe with no trigger, force a trigger on that sample with triggered<=0. A real trigger on the same strobe wins (triggered=1).
- POST: decrement post_cnt per write. On the write that brings it to 0: go to HOLD, frame_done<=1 for exactly one cycle, frame_valid<=1. Frame = PRETRIG + 1 + (DEPTH-PRETRIG-1) = DEPTH samples.
- HOLD: wr_en=0 and sample_en is ignored. Count HOLDOFF cycles, then:
  - Latched mode single -> IDLE; frame_valid stays 1 until the next capture.
  - Otherwise -> PREFILL.
- arm pulse outside IDLE is ignored and not queued.
- Arithmetic:
  - Base subtraction is done in ADDR_W+1 bits; add DEPTH if negative.
  - All counters are sized with $clog2 of their limit.
  - Level compare is unsigned.

Decomposition:
- Shared package scope_pkg:
  - State encodings (ST_IDLE..ST_HOLD).
  - Trigger mode constants (TM_AUTO=2'b00, TM_NORMAL=2'b01, TM_SINGLE=2'b10).
  - Slope constants.
  - Default DATA_W/ADDR_W.
- One sub-module, trig_detect: holds prev/prev_valid and produces a combinational hit from sample_en, sample_in, trig_level and trig_slope, with a clear input for PREFILL entry.

Test Plan:
Bench parameters: DEPTH=16, PRETRIG=4, HOLDOFF=8, AUTO_TO=32, with sample_en every 4th cycle.
1. Reset: hold reset_n=0 -> all outputs 0, state=0. Pulse reset_n low during POST -> state=0, wr_en=0, frame_valid=0 in the same cycle.
2. Normal, rising, level=100, ramp sample k = 20k -> trigger at k=5 (prev 80, cur 100), base_addr=1. Last write k=16 at addr 0, then frame_done pulse, frame_valid=1, triggered=1.
3. Falling slope, level=100, rising ramp as in scenario 2 -> no trigger in normal mode; state stays 2 for more than 100 strobes with no frame_done.
4. Auto mode, constant input 50, level=100 -> forced trigger on the 32nd ARMED strobe, triggered=0, frame_done follows after 11 more writes.
5. Single mode -> no writes until arm. After one frame, state returns to 0 with frame_valid held at 1. An arm pulse during POST is ignored.
6. Wrap boundary: arrange trigger at ptr=2 -> base_addr=14. Confirm wr_addr sequence ..15,0,1.. and exactly 16 writes from base_addr to frame end.
